// File: rtl/hazard_controller.sv
// Hazard and forwarding scheduler for the 5-stage pipelined MIPS core.
// Keeps a shadow copy of the register-use info for the EX, MEM and WB stages.
// From that copy it derives load-use and jr stalls, control-flow flushes, and
// EX/Jr forwarding selects. Saturating counters record stall and flush cycles.
// There is no valid/ready handshake. Every cycle is taken as one pipeline
// advance, and the stall outputs are the only back-pressure on the front end.
module hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRs,
  input  logic                  ID_UsesRt,
  input  logic [REG_ADDR_W-1:0] ID_WriteReg,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_Jump,
  input  logic                  ID_Jr,
  input  logic                  EX_BranchTaken,
  output logic                  PCWrite,
  output logic                  IFID_Write,
  output logic                  IFID_Flush,
  output logic                  IDEX_Flush,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic [1:0]            ForwardJr,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FlushCount
);

  // Shadow pipeline state
  logic [REG_ADDR_W-1:0] exRs, exRt, exWriteReg;
  logic                  exRegWrite, exMemRead;
  logic [REG_ADDR_W-1:0] memWriteReg;
  logic                  memRegWrite, memMemRead;
  logic [REG_ADDR_W-1:0] wbWriteReg;
  logic                  wbRegWrite;

  logic loadUse, jrHaz, stall;

  // A stage produces register x. Register $0 is never a producer.
  function automatic logic regMatch(input logic [REG_ADDR_W-1:0] x,
                                    input logic                  rw,
                                    input logic [REG_ADDR_W-1:0] wr);
    return rw && (wr == x) && (x != '0);
  endfunction

  // EX/MEM wins over MEM/WB. A load in MEM has no data yet, so it cannot forward.
  function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] x,
                                        input logic                  mRw,
                                        input logic                  mMr,
                                        input logic [REG_ADDR_W-1:0] mWr,
                                        input logic                  wRw,
                                        input logic [REG_ADDR_W-1:0] wWr);
    if (regMatch(x, mRw, mWr) && !mMr) return 2'b10;
    else if (regMatch(x, wRw, wWr))    return 2'b01;
    else                               return 2'b00;
  endfunction

  // Hazard detection, pipeline control and forwarding selects
  always_comb begin
    loadUse = exMemRead &&
              ((ID_UsesRs && regMatch(ID_Rs, exRegWrite, exWriteReg)) ||
               (ID_UsesRt && regMatch(ID_Rt, exRegWrite, exWriteReg)));
    // jr resolves in ID, so it must wait for any producer still in EX.
    // It must also wait for a load that is still in MEM.
    jrHaz   = ID_Jr &&
              (regMatch(ID_Rs, exRegWrite, exWriteReg) ||
               (memMemRead && regMatch(ID_Rs, memRegWrite, memWriteReg)));
    // A taken branch squashes the ID instruction, so its hazards are moot.
    stall   = (loadUse || jrHaz) && !EX_BranchTaken;

    PCWrite    = !stall;
    IFID_Write = !stall;
    IDEX_Flush = stall || EX_BranchTaken;
    IFID_Flush = EX_BranchTaken || ((ID_Jump || ID_Jr) && !stall);

    ForwardA  = fwdSel(exRs, memRegWrite, memMemRead, memWriteReg, wbRegWrite, wbWriteReg);
    ForwardB  = fwdSel(exRt, memRegWrite, memMemRead, memWriteReg, wbRegWrite, wbWriteReg);
    ForwardJr = fwdSel(ID_Rs, memRegWrite, memMemRead, memWriteReg, wbRegWrite, wbWriteReg);
  end

  // Shadow stage advance and saturating performance counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      exRs        <= '0;
      exRt        <= '0;
      exWriteReg  <= '0;
      exRegWrite  <= 1'b0;
      exMemRead   <= 1'b0;
      memWriteReg <= '0;
      memRegWrite <= 1'b0;
      memMemRead  <= 1'b0;
      wbWriteReg  <= '0;
      wbRegWrite  <= 1'b0;
      StallCount  <= '0;
      FlushCount  <= '0;
    end else begin
      // A bubble carries no register reads and no register writes.
      exRs        <= IDEX_Flush ? '0 : ID_Rs;
      exRt        <= IDEX_Flush ? '0 : ID_Rt;
      exWriteReg  <= ID_WriteReg;
      exRegWrite  <= IDEX_Flush ? 1'b0 : ID_RegWrite;
      exMemRead   <= IDEX_Flush ? 1'b0 : ID_MemRead;
      memWriteReg <= exWriteReg;
      memRegWrite <= exRegWrite;
      memMemRead  <= exMemRead;
      wbWriteReg  <= memWriteReg;
      wbRegWrite  <= memRegWrite;
      if (stall && (StallCount != '1))
        StallCount <= StallCount + CNT_W'(1);
      if (IFID_Flush && (FlushCount != '1))
        FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Hazard and forwarding scheduler for the 5-stage pipelined MIPS core.
- Sits beside the decode-stage control unit and consumes its per-instruction flags: RegWrite, MemRead, BranchEQ/BranchNE, Jump, Jal, Jr.
- Keeps its own shadow pipeline of destination and source-register info for the EX, MEM and WB stages.
- From that state it drives PC/IF-ID write enables, IF/ID and ID/EX flushes, and EX-stage and Jr forwarding selects. It also counts stall and flush cycles for performance debug.

Parameters:
REG_ADDR_W, 5, register-file address width
CNT_W, 16, width of saturating stall/flush counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
ID_Rs  in  REG_ADDR_W  rs field of instruction in ID
ID_Rt  in  REG_ADDR_W  rt field of instruction in ID
ID_UsesRs  in  1  ID instruction reads rs (includes Jr)
ID_UsesRt  in  1  ID instruction reads rt (R-type, sw, beq, bne)
ID_WriteReg  in  REG_ADDR_W  destination after RegDst/Jal muxing
ID_RegWrite  in  1  from control unit
ID_MemRead  in  1  from control unit (lw)
ID_Jump  in  1  j or jal in ID
ID_Jr  in  1  jr in ID
EX_BranchTaken  in  1  beq/bne in EX resolved taken
PCWrite  out  1  PC load enable
IFID_Write  out  1  IF/ID register load enable
IFID_Flush  out  1  zero IF/ID on next edge
IDEX_Flush  out  1  insert bubble into ID/EX on next edge
ForwardA  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
ForwardB  out  2  EX operand B select, same encoding
ForwardJr  out  2  ID Jr target select, same encoding
StallCount  out  CNT_W  cycles stalled, saturating
FlushCount  out  CNT_W  control-flow flush events, saturating

Behaviour:
- Shadow stages are registered on every rising clk:
  - EX: {Rs, Rt, WriteReg, RegWrite, MemRead}
  - MEM: {WriteReg, RegWrite, MemRead}
  - WB: {WriteReg, RegWrite}
- EX shadow loads the ID fields, with RegWrite, MemRead and Rs/Rt forced to 0 when IDEX_Flush=1. MEM takes EX and WB takes MEM unconditionally.
- reset=0 at a clock edge clears all shadow state and both counters, including mid-stall.
- Reset-state outputs: PCWrite=1, IFID_Write=1, flushes=0, forwards=00, counts=0.
- "Match(x, stage)" means: stage.RegWrite=1, stage.WriteReg==x, and x!=0. Register $0 never matches.
- Stall conditions (combinational from current ID and shadow state):
  - LoadUse: EX.MemRead and ((ID_UsesRs and Match(ID_Rs, EX)) or (ID_UsesRt and Match(ID_Rt, EX))).
  - JrHaz: ID_Jr and (Match(ID_Rs, EX) or (MEM.MemRead and Match(ID_Rs, MEM))).
  - Stall = (LoadUse or JrHaz) and not EX_BranchTaken.
- While Stall=1: PCWrite=0, IFID_Write=0, IDEX_Flush=1.
- Stall durations:
  - Load-use: 1 cycle.
  - Jr after ALU producer: 1 cycle.
  - Jr after lw: 2 cycles.
- EX_BranchTaken=1: IFID_Flush=1, IDEX_Flush=1, PCWrite=1, IFID_Write=1. This overrides any stall, because the ID instruction is on the wrong path.
- ID_Jump=1 or ID_Jr=1, with no stall and no taken branch: IFID_Flush=1 only (delay-slot squash).
- Simultaneous taken branch in EX and jump in ID: the branch wins. IFID_Flush=1 and IDEX_Flush=1; the jump is discarded.
- ForwardA for EX.Rs:
  - 10 if Match(EX.Rs, MEM) and not MEM.MemRead;
  - else 01 if Match(EX.Rs, WB);
  - else 00.
  - EX/MEM has priority over MEM/WB.
- ForwardB uses the same rule for EX.Rt.
- ForwardJr: 10 if Match(ID_Rs, MEM) and not MEM.MemRead, else 01 if Match(ID_Rs, WB), else 00. It is valid only when Stall=0.
- The register file is write-first, so no WB→ID forwarding is generated for normal operand reads.
- StallCount increments on each cycle with Stall=1.
- FlushCount increments on each cycle where IFID_Flush=1, counting one per event. A taken branch counts 1.
- Both counters hold at all-ones and never wrap.
- All non-counter outputs are combinational from inputs and shadow state. There is no added latency.

Test Plan:
1. lw $8 then add $9,$8,$10 in ID → exactly 1 cycle with PCWrite=0, IFID_Write=0, IDEX_Flush=1. Next cycle add in EX with ForwardA=01. StallCount=1.
2. add $8 followed by sub $11,$10,$8 → no stall; ForwardB=10 while sub in EX. A second consumer two instructions later gets 01. If both MEM and WB write $8, the select is 10.
3. addi $0,$0,5 followed by add $9,$0,$0 → ForwardA=ForwardB=00 and no stall.
4. beq taken in EX while ID holds a load-use consumer → IFID_Flush=1, IDEX_Flush=1, PCWrite=1. StallCount unchanged, FlushCount +1.
5. lw $31 then jr $31 → 2 stall cycles (StallCount=2), then ForwardJr=01 with IFID_Flush=1. A 1-cycle stall then ForwardJr=10 is required for addi $31 preceding jr.
6. Drive reset=0 during the second cycle of the Jr stall, then reset=1 → outputs return to the reset state on the next edge, counters 0, and no residual stall.
